// File: rtl/pcie_dllp_pkg.sv
// Shared definitions for the PCIe data link layer DLLP path: type codes,
// CRC-16 constants, transmit FSM states and body packing helpers.
package pcie_dllp_pkg;

    localparam logic [7:0] DLLP_ACK       = 8'h00;
    localparam logic [7:0] DLLP_NAK       = 8'h10;
    localparam logic [7:0] DLLP_NOP       = 8'h31;
    localparam logic [7:0] DLLP_UPDFC_P   = 8'h80;
    localparam logic [7:0] DLLP_UPDFC_NP  = 8'h90;
    localparam logic [7:0] DLLP_UPDFC_CPL = 8'hA0;

    localparam logic [15:0] DLLP_CRC_POLY = 16'h100B;
    localparam logic [15:0] DLLP_CRC_SEED = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BODY = 2'd1,
        ST_CRC  = 2'd2
    } tx_state_t;

    // Bodies are little-endian by byte: byte0 (the type) lands in [7:0].
    function automatic logic [31:0] seq_body(input logic [7:0] dtype, input logic [11:0] seq);
        return {seq[7:0], 4'h0, seq[11:8], 8'h00, dtype};
    endfunction

    function automatic logic [31:0] fc_body(input logic [7:0] dtype, input logic [7:0] hdr,
                                            input logic [11:0] data);
        return {data[7:0], hdr[1:0], 2'b00, data[11:8], 2'b00, hdr[7:2], dtype};
    endfunction

endpackage

// File: rtl/dllp_crc16.sv
// Combinational DLLP CRC-16 over a 4-byte body; the output is already
// complemented and bit-mapped, ready to place in the CRC beat.
module dllp_crc16
    import pcie_dllp_pkg::*;
(
    input  logic [31:0] body,
    output logic [15:0] crc
);

    logic [15:0] lfsr;

    always_comb begin
        lfsr = DLLP_CRC_SEED;
        crc  = '0;
        // Bit i of the packed body is bit (i % 8) of byte (i / 8), so a plain
        // ascending walk feeds byte0 first, bit0 first.
        for (int i = 0; i < 32; i++) begin
            if (lfsr[15] ^ body[i]) begin
                lfsr = {lfsr[14:0], 1'b0} ^ DLLP_CRC_POLY;
            end else begin
                lfsr = {lfsr[14:0], 1'b0};
            end
        end
        // CRC register bit 15 goes out as bit 0 of the first CRC byte.
        for (int k = 0; k < 16; k++) begin
            crc[k] = ~lfsr[15 - k];
        end
    end

endmodule

// File: rtl/dllp_tx_scheduler.sv
// Transmit-side DLLP scheduler: latches Ack/Nak/UpdateFC requests, arbitrates,
// inserts NOPs after an idle gap and streams body + CRC as two beats.
module dllp_tx_scheduler
    import pcie_dllp_pkg::*;
#(
    parameter int NOP_IDLE_CYCLES = 64,
    parameter int CNT_W           = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        link_up,
    input  logic        ack_req,
    input  logic [11:0] ack_seq,
    input  logic        nak_req,
    input  logic [11:0] nak_seq,
    input  logic [2:0]  fc_req,
    input  logic [23:0] fc_hdr,
    input  logic [35:0] fc_data,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    output logic        tx_sop,
    output logic        tx_eop,
    input  logic        tx_ready,
    output logic        dllp_sent,
    output logic [7:0]  sent_type
);

    localparam logic [CNT_W-1:0] NOP_LIMIT = CNT_W'(NOP_IDLE_CYCLES);

    logic             ack_pend;
    logic             nak_pend;
    logic [2:0]       fc_pend;
    logic [11:0]      ack_seq_q;
    logic [11:0]      nak_seq_q;
    logic [2:0][7:0]  fc_hdr_q;
    logic [2:0][11:0] fc_data_q;
    logic [CNT_W-1:0] idle_cnt;

    tx_state_t   state;
    logic [15:0] crc_q;
    logic [7:0]  type_q;

    logic        any_pend;
    logic        nop_due;
    logic        start;
    logic        crc_done;
    logic [31:0] sel_body;
    logic [7:0]  sel_type;
    logic        take_nak;
    logic        take_ack;
    logic [2:0]  take_fc;
    logic [15:0] sel_crc;

    always_comb begin
        any_pend = nak_pend | ack_pend | (|fc_pend);
        nop_due  = (NOP_IDLE_CYCLES != 0) && (idle_cnt == NOP_LIMIT);
        start    = (state == ST_IDLE) && link_up && (any_pend || nop_due);
        crc_done = (state == ST_CRC) && tx_ready;
    end

    // Fixed priority: Nak > Ack > FC-P > FC-NP > FC-Cpl > NOP.
    always_comb begin
        sel_body = {24'h000000, DLLP_NOP};
        sel_type = DLLP_NOP;
        take_nak = 1'b0;
        take_ack = 1'b0;
        take_fc  = 3'b000;
        if (nak_pend) begin
            sel_body = seq_body(DLLP_NAK, nak_seq_q);
            sel_type = DLLP_NAK;
            take_nak = 1'b1;
        end else if (ack_pend) begin
            sel_body = seq_body(DLLP_ACK, ack_seq_q);
            sel_type = DLLP_ACK;
            take_ack = 1'b1;
        end else if (fc_pend[0]) begin
            sel_body   = fc_body(DLLP_UPDFC_P, fc_hdr_q[0], fc_data_q[0]);
            sel_type   = DLLP_UPDFC_P;
            take_fc[0] = 1'b1;
        end else if (fc_pend[1]) begin
            sel_body   = fc_body(DLLP_UPDFC_NP, fc_hdr_q[1], fc_data_q[1]);
            sel_type   = DLLP_UPDFC_NP;
            take_fc[1] = 1'b1;
        end else if (fc_pend[2]) begin
            sel_body   = fc_body(DLLP_UPDFC_CPL, fc_hdr_q[2], fc_data_q[2]);
            sel_type   = DLLP_UPDFC_CPL;
            take_fc[2] = 1'b1;
        end
    end

    dllp_crc16 u_crc (
        .body (sel_body),
        .crc  (sel_crc)
    );

    // A new pulse wins over consumption in the same cycle, so it is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_pend  <= 1'b0;
            nak_pend  <= 1'b0;
            fc_pend   <= 3'b000;
            ack_seq_q <= '0;
            nak_seq_q <= '0;
            fc_hdr_q  <= '0;
            fc_data_q <= '0;
            idle_cnt  <= '0;
        end else begin
            if (ack_req) ack_seq_q <= ack_seq;
            if (nak_req) nak_seq_q <= nak_seq;
            for (int i = 0; i < 3; i++) begin
                if (fc_req[i]) begin
                    fc_hdr_q[i]  <= fc_hdr[8*i +: 8];
                    fc_data_q[i] <= fc_data[12*i +: 12];
                end
            end

            if (!link_up) begin
                ack_pend <= 1'b0;
                nak_pend <= 1'b0;
                fc_pend  <= 3'b000;
            end else begin
                if (nak_req) nak_pend <= 1'b1;
                else if (start && take_nak) nak_pend <= 1'b0;

                // A Nak supersedes any outstanding Ack.
                if (nak_req) ack_pend <= 1'b0;
                else if (ack_req) ack_pend <= 1'b1;
                else if (start && take_ack) ack_pend <= 1'b0;

                for (int i = 0; i < 3; i++) begin
                    if (fc_req[i]) fc_pend[i] <= 1'b1;
                    else if (start && take_fc[i]) fc_pend[i] <= 1'b0;
                end
            end

            if (!link_up || crc_done) begin
                idle_cnt <= '0;
            end else if ((state == ST_IDLE) && !any_pend && (idle_cnt != NOP_LIMIT)) begin
                idle_cnt <= idle_cnt + CNT_W'(1);
            end
        end
    end

    // Valid/ready: a beat transfers on a cycle with tx_valid & tx_ready; while
    // tx_valid is high and tx_ready low, tx_data/tx_sop/tx_eop hold unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            tx_valid  <= 1'b0;
            tx_sop    <= 1'b0;
            tx_eop    <= 1'b0;
            tx_data   <= '0;
            dllp_sent <= 1'b0;
            sent_type <= '0;
            crc_q     <= '0;
            type_q    <= '0;
        end else begin
            dllp_sent <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_BODY;
                        tx_valid <= 1'b1;
                        tx_sop   <= 1'b1;
                        tx_eop   <= 1'b0;
                        tx_data  <= sel_body;
                        crc_q    <= sel_crc;
                        type_q   <= sel_type;
                    end
                end
                ST_BODY: begin
                    if (tx_ready) begin
                        state   <= ST_CRC;
                        tx_sop  <= 1'b0;
                        tx_eop  <= 1'b1;
                        tx_data <= {16'h0000, crc_q};
                    end
                end
                ST_CRC: begin
                    if (tx_ready) begin
                        state     <= ST_IDLE;
                        tx_valid  <= 1'b0;
                        tx_eop    <= 1'b0;
                        tx_data   <= '0;
                        dllp_sent <= 1'b1;
                        sent_type <= type_q;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    tx_valid <= 1'b0;
                    tx_sop   <= 1'b0;
                    tx_eop   <= 1'b0;
                    tx_data  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dllp_tx_scheduler.sv
// Directed bench for dllp_tx_scheduler: a table of single-request DLLPs plus
// hand-written sequences for NOP timing, arbitration, backpressure and link/reset events.
module tb_dllp_tx_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        link_up;
    logic        ack_req;
    logic [11:0] ack_seq;
    logic        nak_req;
    logic [11:0] nak_seq;
    logic [2:0]  fc_req;
    logic [23:0] fc_hdr;
    logic [35:0] fc_data;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_sop;
    logic        tx_eop;
    logic        tx_ready;
    logic        dllp_sent;
    logic [7:0]  sent_type;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          kind;      // 0 Ack, 1 Nak, 2 FC-P, 3 FC-NP, 4 FC-Cpl
        logic [11:0] seq;
        logic [7:0]  hdr;
        logic [11:0] data;
        logic [31:0] exp_body;
        logic [7:0]  exp_type;
    } vec_t;

    vec_t vecs[7];

    dllp_tx_scheduler #(
        .NOP_IDLE_CYCLES (64),
        .CNT_W           (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .link_up   (link_up),
        .ack_req   (ack_req),
        .ack_seq   (ack_seq),
        .nak_req   (nak_req),
        .nak_seq   (nak_seq),
        .fc_req    (fc_req),
        .fc_hdr    (fc_hdr),
        .fc_data   (fc_data),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_sop    (tx_sop),
        .tx_eop    (tx_eop),
        .tx_ready  (tx_ready),
        .dllp_sent (dllp_sent),
        .sent_type (sent_type)
    );

    always #5 clk = ~clk;

    // Reflected (LSB-first) form of the DLLP CRC; reflected result complemented
    // is exactly the transmitted bit order.
    function automatic logic [15:0] crc_model(input logic [31:0] body);
        logic [15:0] r;
        r = 16'hFFFF;
        for (int b = 0; b < 4; b++) begin
            r = r ^ {8'h00, body[8*b +: 8]};
            for (int j = 0; j < 8; j++) begin
                r = r[0] ? ((r >> 1) ^ 16'hD008) : (r >> 1);
            end
        end
        return ~r;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_reqs();
        ack_req = 1'b0;
        nak_req = 1'b0;
        fc_req  = 3'b000;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        link_up  = 1'b0;
        tx_ready = 1'b1;
        clear_reqs();
        step();
        step();
        rst = 1'b0;
    endtask

    // Waits for a body beat (bounded), checks latency, both beats, optional
    // stalls on either beat, and the dllp_sent pulse.
    task automatic expect_dllp(input string name, input logic [31:0] body, input logic [7:0] dtype,
                               input int exp_lat, input int stall_body, input int stall_crc);
        int lat;
        logic [15:0] crc;
        lat = 0;
        crc = crc_model(body);
        while (!tx_valid && lat < 200) begin
            step();
            clear_reqs();
            lat++;
        end
        if (!tx_valid) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: no tx_valid after %0d cycles", name, lat);
            return;
        end
        if (exp_lat >= 0) check({name, "_lat"}, 64'(lat), 64'(exp_lat));
        check({name, "_body"}, 64'(tx_data), 64'(body));
        check({name, "_sop"}, 64'({tx_sop, tx_eop}), 64'(2'b10));
        if (stall_body > 0) begin
            tx_ready = 1'b0;
            for (int i = 0; i < stall_body; i++) begin
                step();
                check({name, "_hold_body"}, {28'h0, tx_valid, tx_sop, tx_eop, dllp_sent, tx_data},
                      {28'h0, 4'b1100, body});
            end
            tx_ready = 1'b1;
        end
        step();
        clear_reqs();
        check({name, "_crc"}, 64'(tx_data), 64'({16'h0000, crc}));
        check({name, "_eop"}, 64'({tx_valid, tx_sop, tx_eop}), 64'(3'b101));
        if (stall_crc > 0) begin
            tx_ready = 1'b0;
            for (int i = 0; i < stall_crc; i++) begin
                step();
                check({name, "_hold_crc"}, {28'h0, tx_valid, tx_sop, tx_eop, dllp_sent, tx_data},
                      {28'h0, 4'b1010, 16'h0000, crc});
            end
            tx_ready = 1'b1;
        end
        step();
        clear_reqs();
        check({name, "_sent"}, 64'({dllp_sent, tx_valid}), 64'(2'b10));
        check({name, "_type"}, 64'(sent_type), 64'(dtype));
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            clear_reqs();
            if (tx_valid || dllp_sent) seen++;
        end
        check(name, 64'(seen), 64'(0));
    endtask

    initial begin
        vecs[0] = '{0, 12'hABC, 8'h00, 12'h000, 32'hBC0A0000, 8'h00};
        vecs[1] = '{1, 12'h123, 8'h00, 12'h000, 32'h23010010, 8'h10};
        vecs[2] = '{0, 12'hFFF, 8'h00, 12'h000, 32'hFF0F0000, 8'h00};
        vecs[3] = '{2, 12'h000, 8'h41, 12'h123, 32'h23411080, 8'h80};
        vecs[4] = '{3, 12'h000, 8'hFF, 12'hFFF, 32'hFFCF3F90, 8'h90};
        vecs[5] = '{4, 12'h000, 8'h02, 12'h800, 32'h008800A0, 8'hA0};
        vecs[6] = '{2, 12'h000, 8'h80, 12'h001, 32'h01002080, 8'h80};

        ack_seq = '0;
        nak_seq = '0;
        fc_hdr  = '0;
        fc_data = '0;
        do_reset();

        check("reset_flags", 64'({tx_valid, tx_sop, tx_eop, dllp_sent}), 64'(4'b0000));
        check("reset_data", 64'(tx_data), 64'(0));
        check("reset_type", 64'(sent_type), 64'(0));

        // NOP after the idle gap, then a second NOP one full gap later.
        link_up = 1'b1;
        expect_dllp("nop1", 32'h00000031, 8'h31, 65, 0, 0);
        expect_dllp("nop2", 32'h00000031, 8'h31, 65, 0, 0);

        foreach (vecs[v]) begin
            do_reset();
            link_up = 1'b1;
            fc_hdr  = 24'($urandom_range(32'hFFFFFF, 0));
            fc_data = {4'($urandom_range(15, 0)), $urandom};
            case (vecs[v].kind)
                0: begin ack_req = 1'b1; ack_seq = vecs[v].seq; end
                1: begin nak_req = 1'b1; nak_seq = vecs[v].seq; end
                default: begin
                    fc_req[vecs[v].kind - 2]                = 1'b1;
                    fc_hdr[8*(vecs[v].kind - 2) +: 8]       = vecs[v].hdr;
                    fc_data[12*(vecs[v].kind - 2) +: 12]    = vecs[v].data;
                end
            endcase
            expect_dllp($sformatf("vec%0d", v), vecs[v].exp_body, vecs[v].exp_type, 2, 0, 0);
            expect_quiet($sformatf("vec%0d_quiet", v), 8);
        end

        // Simultaneous Ack and Nak: only the Nak goes out.
        do_reset();
        link_up = 1'b1;
        ack_req = 1'b1;
        ack_seq = 12'h005;
        nak_req = 1'b1;
        nak_seq = 12'h004;
        expect_dllp("acknak", 32'h04000010, 8'h10, 2, 0, 0);
        expect_quiet("acknak_no_ack", 20);

        // All three FC classes at once, sent back-to-back in priority order.
        do_reset();
        link_up = 1'b1;
        fc_req  = 3'b111;
        fc_hdr  = {8'h0C, 8'h7A, 8'h41};
        fc_data = {12'h456, 12'hABC, 12'h123};
        expect_dllp("fc_p", 32'h23411080, 8'h80, 2, 0, 0);
        expect_dllp("fc_np", 32'hBC8A1E90, 8'h90, 1, 0, 0);
        expect_dllp("fc_cpl", 32'h560403A0, 8'hA0, 1, 0, 0);
        expect_quiet("fc_quiet", 10);

        // Backpressure on both beats.
        do_reset();
        link_up = 1'b1;
        ack_req = 1'b1;
        ack_seq = 12'h321;
        expect_dllp("stall", 32'h21030000, 8'h00, 2, 5, 3);

        // A new Ack in the cycle the first one is consumed is re-armed with the new seq.
        do_reset();
        link_up = 1'b1;
        ack_req = 1'b1;
        ack_seq = 12'h111;
        step();
        ack_seq = 12'h222;
        step();
        clear_reqs();
        expect_dllp("ovr1", 32'h11010000, 8'h00, 0, 0, 0);
        expect_dllp("ovr2", 32'h22020000, 8'h00, 1, 0, 0);
        expect_quiet("ovr_quiet", 10);

        // link_up drops during the CRC beat with an Ack pending.
        do_reset();
        link_up = 1'b1;
        fc_req  = 3'b001;
        fc_hdr  = {16'h0000, 8'h41};
        fc_data = {24'h000000, 12'h123};
        step();
        clear_reqs();
        step();
        check("ldrop_body", {31'h0, tx_valid, tx_data}, {31'h0, 1'b1, 32'h23411080});
        ack_req = 1'b1;
        ack_seq = 12'h777;
        step();
        clear_reqs();
        check("ldrop_crc_beat", 64'({tx_valid, tx_eop}), 64'(2'b11));
        link_up = 1'b0;
        step();
        check("ldrop_sent", 64'({dllp_sent, sent_type}), 64'({1'b1, 8'h80}));
        step();
        step();
        link_up = 1'b1;
        expect_quiet("ldrop_no_ack", 30);

        // Reset while the body beat is on the bus: no partial completion.
        do_reset();
        link_up = 1'b1;
        ack_req = 1'b1;
        ack_seq = 12'h0AA;
        step();
        clear_reqs();
        step();
        check("rstmid_body", {31'h0, tx_valid, tx_data}, {31'h0, 1'b1, 32'hAA000000});
        rst = 1'b1;
        step();
        check("rstmid_out", {28'h0, tx_valid, tx_sop, tx_eop, dllp_sent, tx_data}, 64'(0));
        rst = 1'b0;
        expect_quiet("rstmid_quiet", 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
